// File: rtl/lc3_mem_arbiter_if.sv
// rtl/lc3_mem_arbiter_if.sv - LC3 memory bus (en/we/addr/din/dout/rdy handshake)
interface lc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rdy;

  modport master (output en, output we, output addr, output din, input dout, input rdy);
  modport slave  (input en, input we, input addr, input din, output dout, output rdy);
endinterface

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-port LC3 memory arbiter
// CPU priority with bounded DMA starvation guard and a ready watchdog.
module lc3_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DMA_EVERY = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  lc3_mem_arbiter_if.slave         cpu,
  lc3_mem_arbiter_if.slave         dma,
  lc3_mem_arbiter_if.master        mem,
  output logic [1:0]               grant,
  output logic                     bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] DMA_EVERY_W = 4'(DMA_EVERY);
  localparam logic [7:0] TIMEOUT_W   = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              owner_dma_q, owner_dma_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] dma_dout_q, dma_dout_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              dma_rdy_q, dma_rdy_d;
  logic              bus_err_q, bus_err_d;
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        wdog_q, wdog_d;
  logic              pick_dma;
  logic [7:0]        wdog_inc;

  // DMA wins when alone, or when the CPU has held the bus DMA_EVERY times in a row.
  assign pick_dma = dma.en && (!cpu.en || (streak_q >= DMA_EVERY_W));
  assign wdog_inc = wdog_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    owner_dma_d = owner_dma_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_dout_d  = cpu_dout_q;
    dma_dout_d  = dma_dout_q;
    cpu_rdy_d   = 1'b0;
    dma_rdy_d   = 1'b0;
    bus_err_d   = 1'b0;
    grant_d     = grant_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (!dma.en) streak_d = 4'd0;
        if (cpu.en || dma.en) begin
          owner_dma_d = pick_dma;
          grant_d     = pick_dma ? 2'b10 : 2'b01;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dma ? dma.we   : cpu.we;
          mem_addr_d  = pick_dma ? dma.addr : cpu.addr;
          mem_din_d   = pick_dma ? dma.din  : cpu.din;
          wdog_d      = 8'd0;
          state_d     = ST_BUSY;
          if (pick_dma) begin
            streak_d = 4'd0;
          end else if (dma.en && (streak_q != 4'hF)) begin
            streak_d = streak_q + 4'd1;
          end
        end
      end
      ST_BUSY: begin
        if (mem.rdy) begin
          if (!mem_we_q) begin
            if (owner_dma_q) dma_dout_d = mem.dout;
            else             cpu_dout_d = mem.dout;
          end
          mem_en_d  = 1'b0;
          cpu_rdy_d = !owner_dma_q;
          dma_rdy_d = owner_dma_q;
          state_d   = ST_DONE;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == TIMEOUT_W) begin
            mem_en_d  = 1'b0;
            cpu_rdy_d = !owner_dma_q;
            dma_rdy_d = owner_dma_q;
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d  = 2'b00;
        mem_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_dma_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_dout_q  <= '0;
      dma_dout_q  <= '0;
      cpu_rdy_q   <= 1'b0;
      dma_rdy_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      grant_q     <= 2'b00;
      streak_q    <= 4'd0;
      wdog_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_dma_q <= owner_dma_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_dout_q  <= cpu_dout_d;
      dma_dout_q  <= dma_dout_d;
      cpu_rdy_q   <= cpu_rdy_d;
      dma_rdy_q   <= dma_rdy_d;
      bus_err_q   <= bus_err_d;
      grant_q     <= grant_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem.en   = mem_en_q;
  assign mem.we   = mem_we_q;
  assign mem.addr = mem_addr_q;
  assign mem.din  = mem_din_q;
  assign cpu.dout = cpu_dout_q;
  assign cpu.rdy  = cpu_rdy_q;
  assign dma.dout = dma_dout_q;
  assign dma.rdy  = dma_rdy_q;
  assign grant    = grant_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - self-checking bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;

  localparam int TMO = 64;

  logic clk;
  logic rst;
  logic [1:0] grant, grant1;
  logic bus_err, bus_err1;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dma_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu1_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dma1_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mem1_if ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DMA_EVERY(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu(cpu_if), .dma(dma_if), .mem(mem_if),
    .grant(grant), .bus_err(bus_err));

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DMA_EVERY(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .cpu(cpu1_if), .dma(dma1_if), .mem(mem1_if),
    .grant(grant1), .bus_err(bus_err1));

  // Second instance sees a zero-wait memory returning zero.
  assign mem1_if.rdy  = mem1_if.en;
  assign mem1_if.dout = 16'h0000;

  int total = 0;
  int bad   = 0;
  int mem_wait;
  int mem_cnt;
  bit spur;
  logic [15:0] ram [0:65535];
  logic [15:0] ref_mem [int];
  logic [15:0] ref_cpu, ref_dma;
  logic [1:0]  gseq[$];
  logic [1:0]  gseq1[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic get_rdy(input bit p);
    return p ? dma_if.rdy : cpu_if.rdy;
  endfunction

  function automatic logic [15:0] get_dout(input bit p);
    return p ? dma_if.dout : cpu_if.dout;
  endfunction

  task automatic drive(input bit p, input bit en, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (p) begin
      dma_if.en = en; dma_if.we = we; dma_if.addr = a; dma_if.din = d;
    end else begin
      cpu_if.en = en; cpu_if.we = we; cpu_if.addr = a; cpu_if.din = d;
    end
  endtask

  // Memory model: answers after mem_wait BUSY cycles (never when negative).
  initial begin
    mem_cnt = 0;
    mem_if.rdy = 1'b0;
    mem_if.dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_if.en) begin
        if (mem_wait >= 0 && mem_cnt == mem_wait) begin
          mem_if.rdy = 1'b1;
          if (mem_if.we) begin
            ram[mem_if.addr] = mem_if.din;
            mem_if.dout = 16'($urandom);
          end else begin
            mem_if.dout = ram[mem_if.addr];
          end
        end else begin
          mem_if.rdy = 1'b0;
          mem_if.dout = 16'($urandom);
        end
        mem_cnt++;
      end else begin
        mem_if.rdy = spur;
        mem_if.dout = 16'($urandom);
        mem_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("rdy_excl", cpu_if.rdy & dma_if.rdy, 0);
      chk("cpu_rdy_owner", cpu_if.rdy & (grant != 2'b01), 0);
      chk("dma_rdy_owner", dma_if.rdy & (grant != 2'b10), 0);
      chk("err_without_rdy", bus_err & ~(cpu_if.rdy | dma_if.rdy), 0);
      chk("rdy1_excl", cpu1_if.rdy & dma1_if.rdy, 0);
    end
  end

  task automatic txn(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                     input int waits, input bit keep, input bit chg);
    int n;
    int en_cyc;
    bit tmo;
    tmo = (waits < 0);
    mem_wait = waits;
    drive(p, 1'b1, we, a, d);
    tick();
    chk("busy_mem_en", mem_if.en, 1);
    chk("busy_grant", grant, p ? 2 : 1);
    chk("busy_mem_we", mem_if.we, we);
    chk("busy_mem_addr", mem_if.addr, a);
    if (we) chk("busy_mem_din", mem_if.din, d);
    if (chg) drive(p, 1'b1, we, ~a, ~d);
    n = 1;
    en_cyc = 1;
    while (!get_rdy(p) && n < TMO + 8) begin
      tick();
      n++;
      if (mem_if.en) begin
        en_cyc++;
        chk("hold_addr", mem_if.addr, a);
        if (we) chk("hold_din", mem_if.din, d);
      end
    end
    chk("latency", n, tmo ? TMO + 1 : waits + 2);
    chk("mem_en_cycles", en_cyc, tmo ? TMO : waits + 1);
    chk("rdy", get_rdy(p), 1);
    chk("other_rdy", get_rdy(!p), 0);
    chk("bus_err", bus_err, tmo);
    chk("done_grant", grant, p ? 2 : 1);
    chk("done_mem_en", mem_if.en, 0);
    if (!tmo && !we) begin
      if (p) ref_dma = model_rd(a);
      else   ref_cpu = model_rd(a);
    end
    if (!tmo && we) ref_mem[int'(a)] = d;
    chk("dout", get_dout(p), p ? ref_dma : ref_cpu);
    chk("other_dout", get_dout(!p), p ? ref_cpu : ref_dma);
    if (!keep) drive(p, 1'b0, we, a, d);
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_rdy", cpu_if.rdy | dma_if.rdy, 0);
    chk("idle_bus_err", bus_err, 0);
  endtask

  initial begin
    int s;
    logic [1:0] prev;
    logic [1:0] expg;
    bit p, we;
    logic [15:0] a, d;
    int w;

    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'hA5A5;
    ram[16'h3000] = 16'hBEEF;
    ref_mem[16'h3000] = 16'hBEEF;
    ref_cpu = 16'h0000;
    ref_dma = 16'h0000;
    spur = 1'b0;
    mem_wait = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    cpu1_if.en = 1'b0; cpu1_if.we = 1'b0; cpu1_if.addr = 16'h0; cpu1_if.din = 16'h0;
    dma1_if.en = 1'b0; dma1_if.we = 1'b0; dma1_if.addr = 16'h0; dma1_if.din = 16'h0;
    repeat (3) tick();

    chk("rst_mem_en", mem_if.en, 0);
    chk("rst_mem_we", mem_if.we, 0);
    chk("rst_mem_addr", mem_if.addr, 0);
    chk("rst_mem_din", mem_if.din, 0);
    chk("rst_grant", grant, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rdy", {cpu_if.rdy, dma_if.rdy}, 0);
    chk("rst_cpu_dout", cpu_if.dout, 0);
    chk("rst_dma_dout", dma_if.dout, 0);
    rst = 1'b0;
    tick();

    txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 1'b0, 1'b0);
    chk("cpu_read_beef", cpu_if.dout, 16'hBEEF);
    txn(1'b1, 1'b1, 16'h4000, 16'h1234, 3, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 16'h4000, 16'h0000, 1, 1'b0, 1'b0);
    chk("dma_readback", dma_if.dout, 16'h1234);

    mem_wait = 0;
    drive(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h4000, 16'h0);
    prev = 2'b00;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (grant != 2'b00 && prev == 2'b00) gseq.push_back(grant);
      prev = grant;
    end
    drive(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h4000, 16'h0);
    tick();
    ref_cpu = model_rd(16'h3000);
    ref_dma = model_rd(16'h4000);
    chk("arb4_count", gseq.size(), 15);
    s = 0;
    for (int k = 0; k < gseq.size(); k++) begin
      if (s >= 4) begin expg = 2'b10; s = 0; end
      else        begin expg = 2'b01; s++;   end
      chk("arb4_seq", gseq[k], expg);
    end

    cpu1_if.en = 1'b1;
    dma1_if.en = 1'b1;
    prev = 2'b00;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (grant1 != 2'b00 && prev == 2'b00) gseq1.push_back(grant1);
      prev = grant1;
    end
    cpu1_if.en = 1'b0;
    dma1_if.en = 1'b0;
    tick();
    chk("arb1_count", gseq1.size(), 15);
    s = 0;
    for (int k = 0; k < gseq1.size(); k++) begin
      if (s >= 1) begin expg = 2'b10; s = 0; end
      else        begin expg = 2'b01; s++;   end
      chk("arb1_seq", gseq1[k], expg);
    end
    chk("arb1_bus_err", bus_err1, 0);
    chk("arb1_dout", {cpu1_if.dout, dma1_if.dout}, 0);

    txn(1'b0, 1'b0, 16'h3004, 16'h0000, -1, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 1'b0, 1'b0);

    txn(1'b0, 1'b0, 16'h3010, 16'h0000, 2, 1'b1, 1'b1);
    txn(1'b0, 1'b0, ~16'h3010, 16'h0000, 0, 1'b0, 1'b0);

    mem_wait = 20;
    drive(1'b1, 1'b1, 1'b0, 16'h4100, 16'h0);
    tick();
    chk("pre_rst_grant", grant, 2'b10);
    drive(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h4100, 16'h0);
    chk("midrst_mem_en", mem_if.en, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_dma_rdy", dma_if.rdy, 0);
    chk("midrst_douts", {cpu_if.dout, dma_if.dout}, 0);
    ref_cpu = 16'h0000;
    ref_dma = 16'h0000;
    txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 16'h5000 + 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      w  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
      txn(p, we, a, d, w, 1'b0, 1'b0);
      spur = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      spur = 1'b0;
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Two-port memory arbiter that shares the single LC3 memory bus (addr/din/dout/WE/EN/RDY handshake) between the CPU core (port 0) and a DMA/loader master (port 1). It sits between the lc3 core and the memory model inside the top-level harness. It serialises one transaction at a time and uses CPU-priority arbitration with a bounded DMA starvation guard. A watchdog aborts transactions when memory never returns ready.

Parameters:
ADDR_W, 16, address width of both ports and memory side
DATA_W, 16, data width
DMA_EVERY, 4, when both ports request continuously, DMA wins after this many consecutive CPU grants (legal 1..15; 1 = strict alternation)
TIMEOUT, 64, max BUSY cycles awaiting mem_rdy before abort (legal 2..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cpu_en  in  1  CPU request, held high until cpu_rdy seen
cpu_we  in  1  CPU write enable (1 = write)
cpu_addr  in  ADDR_W  CPU address
cpu_din  in  DATA_W  CPU write data
cpu_dout  out  DATA_W  CPU read data, valid when cpu_rdy=1
cpu_rdy  out  1  one-cycle completion pulse to CPU
dma_en, dma_we, dma_addr, dma_din, dma_dout, dma_rdy  same as cpu_* for DMA port
mem_en  out  1  memory request, held for whole transaction
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  write data to memory
mem_dout  in  DATA_W  read data from memory
mem_rdy  in  1  memory completion, sampled only while mem_en=1
grant  out  2  one-hot owner {dma,cpu} during BUSY/DONE, 0 in IDLE
bus_err  out  1  one-cycle pulse coincident with rdy when transaction timed out

Behaviour:
- Reset: state IDLE; mem_en, mem_we, cpu_rdy, dma_rdy, bus_err, grant = 0; mem_addr, mem_din, cpu_dout, dma_dout = 0; streak and watchdog counters = 0. Reset mid-transaction abandons it: mem_en low the cycle after rst sampled, no rdy pulse issued.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE: sample cpu_en/dma_en. None: stay. One: grant it. Both: grant DMA if streak >= DMA_EVERY, else CPU. On grant, register owner's addr/din/we onto mem_*; set mem_en=1 and grant; clear watchdog; go BUSY.
- streak: +1 (saturating at 15) on each CPU grant made while dma_en=1; cleared on DMA grant or on any IDLE sample with dma_en=0.
- BUSY: mem_* held stable. mem_rdy=1 -> capture mem_dout into owner's dout if read (writes leave dout unchanged); mem_en=0; owner rdy=1; go DONE. Else watchdog +1; reaching TIMEOUT -> mem_en=0, owner rdy=1, bus_err=1, owner dout unchanged, go DONE.
- DONE: exactly one cycle; rdy and bus_err clear on exit; grant clears on exit; go IDLE. Requester must drop en at the edge ending DONE; en still high when IDLE samples counts as a new request.
- Latency: en high in cycle 0, zero-wait memory (mem_rdy in cycle 1) -> rdy in cycle 2; back-to-back throughput one transaction per 3 cycles. Each memory wait cycle adds one.
- Requester inputs are ignored outside IDLE; changes to addr/din during BUSY have no effect.
- mem_rdy outside BUSY is ignored.
- Non-owner rdy never asserts; cpu_rdy and dma_rdy never high together.

Test Plan:
- CPU read only, addr 16'h3000, memory returns 16'hBEEF with 0 wait -> mem_en cycles 1 only, cpu_rdy cycle 2, cpu_dout=16'hBEEF, grant=01, dma_rdy never high.
- DMA write addr 16'h4000 data 16'h1234, memory waits 3 cycles -> mem_we=1, mem_din=16'h1234 held 4 cycles, dma_rdy 1 cycle after mem_rdy, dma_dout unchanged.
- Both request continuously, DMA_EVERY=4 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU... repeating; with DMA_EVERY=1 -> strict alternation.
- Memory never asserts mem_rdy, TIMEOUT=64 -> mem_en high exactly 64 cycles, then cpu_rdy and bus_err pulse together for 1 cycle, cpu_dout unchanged, next request proceeds normally.
- rst asserted during BUSY of DMA read -> next cycle mem_en=0, grant=0, no dma_rdy; after release, pending cpu_en granted normally.
- Requester keeps en high through DONE -> treated as new request in following IDLE; addr change during BUSY does not alter mem_addr.
